// File: rtl/sad_tree_min_select.sv
// rtl/sad_tree_min_select.sv - pipelined SAD adder tree with per-partition minimum tracking
//
// Reduces the PE array's 32x32 absolute differences to sixteen 8x8, four 16x16
// and one 32x32 SAD per candidate. It also keeps the smallest SAD and its tag per
// partition over a search window.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   abs_outs            1024 absolute differences, pixel (i,j) at index 32i+j
//   abs_valid, mv_in    sample qualifier and candidate tag
//   search_start        opens a new window (flushes in-flight samples)
//   search_end          marks this cycle's slot as the last of the window
//   best_sad_*/best_mv_* per-partition minimum SAD and its tag
//   done                one-cycle pulse when best_* are final for the window
module sad_tree_min_select #(
  parameter int PIXEL = 8,
  parameter int MV_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1024*PIXEL-1:0]    abs_outs,
  input  logic                     abs_valid,
  input  logic [MV_W-1:0]          mv_in,
  input  logic                     search_start,
  input  logic                     search_end,
  output logic [16*(PIXEL+6)-1:0]  best_sad_8x8,
  output logic [16*MV_W-1:0]       best_mv_8x8,
  output logic [4*(PIXEL+8)-1:0]   best_sad_16x16,
  output logic [4*MV_W-1:0]        best_mv_16x16,
  output logic [PIXEL+9:0]         best_sad_32x32,
  output logic [MV_W-1:0]          best_mv_32x32,
  output logic                     done
);

  localparam int RW = PIXEL + 3;   // 8-pixel row sum
  localparam int BW = PIXEL + 6;   // 8x8 SAD
  localparam int QW = PIXEL + 8;   // 16x16 SAD
  localparam int WW = PIXEL + 10;  // 32x32 SAD

  // Stage 0: captured sample
  logic [1024*PIXEL-1:0] abs_q;
  logic [MV_W-1:0]       mv0, mv1, mv2, mv3, mv4;

  // Stage 1..4 data; 8x8/16x16 copies are delay-matched to the 32x32 sum
  logic [RW-1:0] row_c [128];
  logic [RW-1:0] row_q [128];
  logic [BW-1:0] blk_c [16];
  logic [BW-1:0] blk_q [16];
  logic [BW-1:0] blk3  [16];
  logic [BW-1:0] blk4  [16];
  logic [QW-1:0] quad_c [4];
  logic [QW-1:0] quad_q [4];
  logic [QW-1:0] quad4  [4];
  logic [WW-1:0] whole_c;
  logic [WW-1:0] whole_q;

  // Per-slot valid and end-of-window flags, one per stage
  logic [4:0] vld;
  logic [4:0] fin;

  // Running minima
  logic [BW-1:0]   best8   [16];
  logic [MV_W-1:0] bmv8    [16];
  logic [QW-1:0]   best16  [4];
  logic [MV_W-1:0] bmv16   [4];
  logic [WW-1:0]   best32;
  logic [MV_W-1:0] bmv32;

  always_comb begin
    for (int r = 0; r < 128; r++) begin
      // row r covers pixel row r/4, columns 8*(r%4) .. 8*(r%4)+7
      row_c[r] = '0;
      for (int k = 0; k < 8; k++)
        row_c[r] = row_c[r] + RW'(abs_q[((r / 4) * 32 + (r % 4) * 8 + k) * PIXEL +: PIXEL]);
    end
    for (int b = 0; b < 16; b++) begin
      blk_c[b] = '0;
      for (int k = 0; k < 8; k++)
        blk_c[b] = blk_c[b] + BW'(row_q[((b / 4) * 8 + k) * 4 + (b % 4)]);
    end
    for (int q = 0; q < 4; q++) begin
      quad_c[q] = QW'(blk_q[(q / 2) * 8 + (q % 2) * 2])     + QW'(blk_q[(q / 2) * 8 + (q % 2) * 2 + 1])
                + QW'(blk_q[(q / 2) * 8 + (q % 2) * 2 + 4]) + QW'(blk_q[(q / 2) * 8 + (q % 2) * 2 + 5]);
    end
    whole_c = WW'(quad_q[0]) + WW'(quad_q[1]) + WW'(quad_q[2]) + WW'(quad_q[3]);
  end

  // Datapath registers carry no reset; the flag pipeline qualifies them.
  always_ff @(posedge clk) begin
    abs_q   <= abs_outs;
    mv0     <= mv_in;
    mv1     <= mv0;
    mv2     <= mv1;
    mv3     <= mv2;
    mv4     <= mv3;
    row_q   <= row_c;
    blk_q   <= blk_c;
    blk3    <= blk_q;
    blk4    <= blk3;
    quad_q  <= quad_c;
    quad4   <= quad_q;
    whole_q <= whole_c;
  end

  // The window state (open / draining) lives in the fin flags travelling
  // with the data, so done simply falls out of the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      fin <= '0;
    end else if (search_start) begin
      vld <= {4'b0, abs_valid};
      fin <= {4'b0, search_end};
    end else begin
      vld <= {vld[3:0], abs_valid};
      fin <= {fin[3:0], search_end};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || search_start) begin
      for (int b = 0; b < 16; b++) begin
        best8[b] <= '1;
        bmv8[b]  <= '0;
      end
      for (int q = 0; q < 4; q++) begin
        best16[q] <= '1;
        bmv16[q]  <= '0;
      end
      best32 <= '1;
      bmv32  <= '0;
      done   <= 1'b0;
    end else begin
      done <= fin[4];
      if (vld[4]) begin
        // strict less-than: on a tie the earlier candidate is kept
        for (int b = 0; b < 16; b++) begin
          if (blk4[b] < best8[b]) begin
            best8[b] <= blk4[b];
            bmv8[b]  <= mv4;
          end
        end
        for (int q = 0; q < 4; q++) begin
          if (quad4[q] < best16[q]) begin
            best16[q] <= quad4[q];
            bmv16[q]  <= mv4;
          end
        end
        if (whole_q < best32) begin
          best32 <= whole_q;
          bmv32  <= mv4;
        end
      end
    end
  end

  for (genvar b = 0; b < 16; b++) begin : g_out8
    assign best_sad_8x8[b*BW +: BW]    = best8[b];
    assign best_mv_8x8[b*MV_W +: MV_W] = bmv8[b];
  end
  for (genvar q = 0; q < 4; q++) begin : g_out16
    assign best_sad_16x16[q*QW +: QW]    = best16[q];
    assign best_mv_16x16[q*MV_W +: MV_W] = bmv16[q];
  end
  assign best_sad_32x32 = best32;
  assign best_mv_32x32  = bmv32;

endmodule

// File: tb/tb_sad_tree_min_select.sv
// tb/tb_sad_tree_min_select.sv - directed self-checking bench for sad_tree_min_select
module tb_sad_tree_min_select;
  localparam int PIXEL = 8;
  localparam int MV_W  = 12;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [1024*PIXEL-1:0]   abs_outs;
  logic                    abs_valid;
  logic [MV_W-1:0]         mv_in;
  logic                    search_start;
  logic                    search_end;
  logic [16*14-1:0]        best_sad_8x8;
  logic [16*MV_W-1:0]      best_mv_8x8;
  logic [4*16-1:0]         best_sad_16x16;
  logic [4*MV_W-1:0]       best_mv_16x16;
  logic [17:0]             best_sad_32x32;
  logic [MV_W-1:0]         best_mv_32x32;
  logic                    done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sad_tree_min_select #(.PIXEL(PIXEL), .MV_W(MV_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .abs_outs       (abs_outs),
    .abs_valid      (abs_valid),
    .mv_in          (mv_in),
    .search_start   (search_start),
    .search_end     (search_end),
    .best_sad_8x8   (best_sad_8x8),
    .best_mv_8x8    (best_mv_8x8),
    .best_sad_16x16 (best_sad_16x16),
    .best_mv_16x16  (best_mv_16x16),
    .best_sad_32x32 (best_sad_32x32),
    .best_mv_32x32  (best_mv_32x32),
    .done           (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic fill(input int val);
    for (int p = 0; p < 1024; p++)
      abs_outs[p*PIXEL +: PIXEL] = PIXEL'(val);
  endtask

  task automatic fill_block(input int b, input int val);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        abs_outs[(((b / 4) * 8 + i) * 32 + (b % 4) * 8 + j) * PIXEL +: PIXEL] = PIXEL'(val);
  endtask

  // Present one cycle of controls, take edge, then return inputs to idle.
  task automatic drive(input bit v, input bit s, input bit e, input int mv);
    abs_valid    = v;
    search_start = s;
    search_end   = e;
    mv_in        = MV_W'(mv);
    @(posedge clk); #1;
    abs_valid    = 1'b0;
    search_start = 1'b0;
    search_end   = 1'b0;
  endtask

  // Called right after the search_end edge; done must arrive 5 edges later.
  task automatic wait_done(input string tag);
    int lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_done_lat"}, lat, 5);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic check_uniform(input string tag, input int e8, input int e16, input int e32, input int emv);
    for (int b = 0; b < 16; b++) begin
      check($sformatf("%s_sad8_%0d", tag, b), best_sad_8x8[14*b +: 14], e8);
      check($sformatf("%s_mv8_%0d", tag, b), best_mv_8x8[MV_W*b +: MV_W], emv);
    end
    for (int q = 0; q < 4; q++) begin
      check($sformatf("%s_sad16_%0d", tag, q), best_sad_16x16[16*q +: 16], e16);
      check($sformatf("%s_mv16_%0d", tag, q), best_mv_16x16[MV_W*q +: MV_W], emv);
    end
    check({tag, "_sad32"}, best_sad_32x32, e32);
    check({tag, "_mv32"}, best_mv_32x32, emv);
  endtask

  initial begin
    int cnt;
    rst_n        = 1'b0;
    abs_outs     = '0;
    abs_valid    = 1'b0;
    mv_in        = '0;
    search_start = 1'b0;
    search_end   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("reset_done", done, 0);
    check_uniform("reset", 16'h3FFF, 16'hFFFF, 18'h3FFFF, 0);

    // single sample, all ones
    fill(1);
    drive(1, 1, 1, 12'h005);
    wait_done("ones");
    check_uniform("ones", 64, 256, 1024, 12'h005);

    // results hold after done
    repeat (3) @(posedge clk);
    #1;
    check_uniform("hold", 64, 256, 1024, 12'h005);

    // maximum values, no overflow
    fill(255);
    drive(1, 1, 1, 12'h0AA);
    wait_done("max");
    check_uniform("max", 16320, 65280, 261120, 12'h0AA);

    // three candidates; tie between B and C keeps B
    fill(3); drive(1, 1, 0, 12'h111);
    fill(2); drive(1, 0, 0, 12'h222);
    fill(2); drive(1, 0, 1, 12'h333);
    wait_done("tie");
    check_uniform("tie", 128, 512, 2048, 12'h222);

    // block-specific minima
    fill(9); fill_block(5, 0); drive(1, 1, 0, 12'h001);
    fill(4); drive(1, 0, 1, 12'h002);
    wait_done("blk");
    for (int b = 0; b < 16; b++) begin
      check($sformatf("blk_sad8_%0d", b), best_sad_8x8[14*b +: 14], (b == 5) ? 0 : 256);
      check($sformatf("blk_mv8_%0d", b), best_mv_8x8[MV_W*b +: MV_W], (b == 5) ? 1 : 2);
    end
    for (int q = 0; q < 4; q++) begin
      check($sformatf("blk_sad16_%0d", q), best_sad_16x16[16*q +: 16], 1024);
      check($sformatf("blk_mv16_%0d", q), best_mv_16x16[MV_W*q +: MV_W], 2);
    end
    check("blk_sad32", best_sad_32x32, 4096);
    check("blk_mv32", best_mv_32x32, 2);

    // empty window reports all-ones / zero tags
    drive(0, 1, 1, 12'h7FF);
    wait_done("empty");
    check_uniform("empty", 16'h3FFF, 16'hFFFF, 18'h3FFFF, 0);

    // flush: the abs=0 sample is still in flight when the new window opens
    fill(0); drive(1, 1, 0, 12'h0F0);
    drive(0, 0, 0, 0);
    fill(5); drive(1, 1, 0, 12'h055);
    fill(6); drive(1, 0, 1, 12'h066);
    wait_done("flush");
    check_uniform("flush", 320, 1280, 5120, 12'h055);

    // reset during drain: no done, everything back to reset state
    fill(1);
    drive(1, 1, 1, 12'h005);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("rst_no_done", cnt, 0);
    check_uniform("rst", 16'h3FFF, 16'hFFFF, 18'h3FFFF, 0);

    // normal search after the aborted window
    fill(1);
    drive(1, 1, 1, 12'h00C);
    wait_done("post");
    check_uniform("post", 64, 256, 1024, 12'h00C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
